// File: rtl/half_adder_core.sv
// half_adder_core: bit-parallel half adder.
// Provides a combinational sum/carry per lane, a registered copy of the
// last accepted sample with a one-cycle valid strobe, and a saturating
// count of accepted samples that produced at least one carry bit.
module half_adder_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;
  logic [CNT_W-1:0] carry_cnt_d;

  // Lanes are independent: no carry ripples between bit positions, and this
  // path ignores clock, reset and the qualifiers entirely.
  assign sum   = a ^ b;
  assign carry = a & b;

  // Next-state: capture on in_valid, otherwise hold the result and drop the
  // strobe; clear wins over a same-cycle increment, and the counter sticks
  // at all-ones rather than wrapping.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    carry_cnt_d = carry_cnt;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
    end
    if (clr) begin
      carry_cnt_d = '0;
    end else if (in_valid && (|carry) && (carry_cnt != CntMax)) begin
      carry_cnt_d = carry_cnt + CntOne;
    end
  end

  // State register; reset discards any in-flight sample immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= out_valid_d;
      carry_cnt <= carry_cnt_d;
    end
  end

endmodule

// File: tb/tb_half_adder_core.sv
// tb_half_adder_core: directed and randomized checks of half_adder_core
// against a behavioural model kept in this bench.
module tb_half_adder_core;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             clr;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int mSum   = 0;
  int mCarry = 0;
  int mValid = 0;
  int mCnt   = 0;

  half_adder_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .clr       (clr),
    .sum       (sum),
    .carry     (carry),
    .sum_q     (sum_q),
    .carry_q   (carry_q),
    .out_valid (out_valid),
    .carry_cnt (carry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV, input logic v, input logic c);
    a        = aV;
    b        = bV;
    in_valid = v;
    clr      = c;
  endtask

  // Reference model: a sample is taken when in_valid is high at an edge out of
  // reset; the carry counter counts such samples having any carry, capped.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSum = 0; mCarry = 0; mValid = 0; mCnt = 0;
    end else begin
      if (clr) mCnt = 0;
      else if (in_valid && ((a & b) != 0)) mCnt = (mCnt >= CNT_MAX) ? CNT_MAX : mCnt + 1;
      if (in_valid) begin
        mSum   = int'(a ^ b);
        mCarry = int'(a & b);
        mValid = 1;
      end else begin
        mValid = 0;
      end
    end
  end

  // Compare DUT against the model shortly after every rising edge.
  always @(posedge clk) begin
    #2;
    checkOutput("cmp_sum",       64'(sum),       64'(a ^ b));
    checkOutput("cmp_carry",     64'(carry),     64'(a & b));
    checkOutput("cmp_sum_q",     64'(sum_q),     64'(mSum));
    checkOutput("cmp_carry_q",   64'(carry_q),   64'(mCarry));
    checkOutput("cmp_out_valid", 64'(out_valid), 64'(mValid));
    checkOutput("cmp_carry_cnt", 64'(carry_cnt), 64'(mCnt));
  end

  initial begin
    // Reset with combinational path live
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0011, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_sum_q",     64'(sum_q),     64'd0);
    checkOutput("rst_carry_q",   64'(carry_q),   64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_carry_cnt", 64'(carry_cnt), 64'd0);
    checkOutput("rst_comb_sum",  64'(sum),       64'h c);
    checkOutput("rst_comb_carry",64'(carry),     64'h3);

    // Truth table with in_valid low, changes every 10 units
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("tt00_sum", 64'(sum), 64'h0); checkOutput("tt00_carry", 64'(carry), 64'h0);
    #9 applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0); #1;
    checkOutput("tt01_sum", 64'(sum), 64'hf); checkOutput("tt01_carry", 64'(carry), 64'h0);
    #9 applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0); #1;
    checkOutput("tt10_sum", 64'(sum), 64'hf); checkOutput("tt10_carry", 64'(carry), 64'h0);
    #9 applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0); #1;
    checkOutput("tt11_sum", 64'(sum), 64'h0); checkOutput("tt11_carry", 64'(carry), 64'hf);

    // Registered latency
    @(negedge clk);
    applyStimulus(4'b1100, 4'b1010, 1'b1, 1'b0);
    #1;
    checkOutput("lat_comb_sum",   64'(sum),   64'h6);
    checkOutput("lat_comb_carry", 64'(carry), 64'h8);
    @(negedge clk);
    checkOutput("lat_sum_q",   64'(sum_q),     64'h6);
    checkOutput("lat_carry_q", 64'(carry_q),   64'h8);
    checkOutput("lat_valid",   64'(out_valid), 64'd1);
    checkOutput("lat_cnt",     64'(carry_cnt), 64'd1);
    applyStimulus(4'b1100, 4'b1010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lat_valid_drop", 64'(out_valid), 64'd0);

    // Hold after in_valid drops
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold_sum_q",   64'(sum_q),     64'h0);
    checkOutput("hold_carry_q", 64'(carry_q),   64'h1);
    checkOutput("hold_valid",   64'(out_valid), 64'd0);
    checkOutput("hold_comb_sum",64'(sum),       64'h1);
    checkOutput("hold_cnt",     64'(carry_cnt), 64'd2);

    // Clear beats a simultaneous carry sample
    applyStimulus(4'b0011, 4'b0001, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("clr_cnt",     64'(carry_cnt), 64'd0);
    checkOutput("clr_sum_q",   64'(sum_q),     64'h2);
    checkOutput("clr_carry_q", 64'(carry_q),   64'h1);
    checkOutput("clr_valid",   64'(out_valid), 64'd1);

    // Sample without carry does not count
    applyStimulus(4'b0001, 4'b0010, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("nocarry_cnt", 64'(carry_cnt), 64'd0);

    // Saturation: 1,2,3,3,3
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("sat_cnt", 64'(carry_cnt), 64'((i < 3) ? i + 1 : 3));
    end

    // Async reset mid-stream while out_valid is high
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_sum_q",     64'(sum_q),     64'd0);
    checkOutput("ar_carry_q",   64'(carry_q),   64'd0);
    checkOutput("ar_valid",     64'(out_valid), 64'd0);
    checkOutput("ar_cnt",       64'(carry_cnt), 64'd0);
    applyStimulus(4'b0111, 4'b0101, 1'b1, 1'b0);
    #1;
    checkOutput("ar_comb_sum",   64'(sum),   64'h2);
    checkOutput("ar_comb_carry", 64'(carry), 64'h5);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 4'b1100, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ar_rel_sum_q",   64'(sum_q),     64'h5);
    checkOutput("ar_rel_carry_q", 64'(carry_q),   64'h8);
    checkOutput("ar_rel_valid",   64'(out_valid), 64'd1);
    checkOutput("ar_rel_cnt",     64'(carry_cnt), 64'd1);

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
